// File: rtl/pc_mt_unit_pkg.sv
// Shared types and redirect-target helper for the multi-context PC unit.
package pc_mt_unit_pkg;

  // Width of the jump index field carried by J-type instructions.
  localparam int ADDR_W = 26;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_t;

  typedef enum logic {
    CTX_RUN    = 1'b0,
    CTX_HALTED = 1'b1
  } ctx_state_t;

  // New PC for a redirect; npc is the address after the redirecting instruction.
  // PC_SEQ returns npc, but callers treat PC_SEQ as "no redirect".
  function automatic logic [31:0] redirect_target(
    input pc_src_t           src,
    input logic [31:0]       redir_pc,
    input logic              taken,
    input logic [31:0]       imm16,
    input logic [ADDR_W-1:0] imm26,
    input logic [31:0]       regval
  );
    logic [31:0] npc;
    logic [31:0] result;
    npc = redir_pc + 32'd4;
    case (src)
      PC_SEQ:  result = npc;
      PC_BR:   result = taken ? (npc + (imm16 << 2)) : npc;
      PC_J:    result = {npc[31:28], imm26, 2'b00};
      PC_JR:   result = regval & 32'hFFFF_FFFC;
      default: result = npc;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_mt_unit_rr_arbiter.sv
// Picks one requesting context: round-robin from ptr with wrap, or lowest index.
module pc_mt_unit_rr_arbiter
  import pc_mt_unit_pkg::*;
#(
  parameter int N     = 2,
  parameter bit RR_EN = 1'b1,
  localparam int W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         valid
);

  // Search the request vector for the first eligible context.
  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    if (RR_EN) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end else begin
          idx = idx;
        end
        if (!valid && req[idx]) begin
          grant = W'(idx);
          valid = 1'b1;
        end else begin
          valid = valid;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!valid && req[k]) begin
          grant = W'(k);
          valid = 1'b1;
        end else begin
          valid = valid;
        end
      end
    end
  end

endmodule

// File: rtl/pc_mt_unit.sv
// Multi-context program counter: N PCs, per-context run/halt, one fetch per cycle.
module pc_mt_unit
  import pc_mt_unit_pkg::*;
#(
  parameter int          NCTX       = 2,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] CTX_STRIDE = 32'h0000_0200,
  parameter bit          RR_EN      = 1'b1,
  localparam int         CTXW       = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pcEN,
  input  logic              redir_valid,
  input  logic [CTXW-1:0]   redir_ctx,
  input  logic [31:0]       redir_pc,
  input  logic [1:0]        pc_src,
  input  logic              branchmux,
  input  logic [31:0]       imm16,
  input  logic [ADDR_W-1:0] imm26,
  input  logic [31:0]       regval,
  input  logic              halt_req,
  input  logic [CTXW-1:0]   halt_ctx,
  input  logic [NCTX-1:0]   start,
  output logic [31:0]       imemaddr,
  output logic [CTXW-1:0]   fetch_ctx,
  output logic              fetch_valid,
  output logic [NCTX-1:0]   halted,
  output logic              all_halted
);

  logic [31:0]     pc [NCTX];
  ctx_state_t      state [NCTX];
  logic [CTXW-1:0] rr_ptr;
  logic [CTXW-1:0] sel;
  logic            any_run;
  logic [NCTX-1:0] run;
  logic            redir_hit;
  logic            halt_hit;
  logic [31:0]     target;

  // Decode per-context run/halt flags from the state array.
  always_comb begin
    run    = '0;
    halted = '0;
    for (int i = 0; i < NCTX; i++) begin
      run[i]    = (state[i] == CTX_RUN);
      halted[i] = (state[i] == CTX_HALTED);
    end
    all_halted = &halted;
  end

  pc_mt_unit_rr_arbiter #(
    .N     (NCTX),
    .RR_EN (RR_EN)
  ) u_arb (
    .req   (run),
    .ptr   (rr_ptr),
    .grant (sel),
    .valid (any_run)
  );

  // Redirect/halt qualification, target computation and fetch outputs.
  always_comb begin
    target    = redirect_target(pc_src_t'(pc_src), redir_pc, branchmux,
                                imm16, imm26, regval);
    redir_hit = redir_valid && (pc_src_t'(pc_src) != PC_SEQ) &&
                (32'(redir_ctx) < 32'(NCTX));
    halt_hit  = halt_req && (32'(halt_ctx) < 32'(NCTX));
    fetch_valid = pcEN && any_run;
    // With nothing runnable the address still tracks the rr pointer's PC.
    if (any_run) begin
      imemaddr  = pc[sel] & 32'hFFFF_FFFC;
      fetch_ctx = sel;
    end else begin
      imemaddr  = pc[rr_ptr] & 32'hFFFF_FFFC;
      fetch_ctx = rr_ptr;
    end
  end

  // PC array, context states and rr pointer; halt > redirect-state, redirect > +4.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NCTX; i++) begin
        pc[i]    <= PC_RESET + CTX_STRIDE * 32'(i);
        state[i] <= (i == 0) ? CTX_RUN : CTX_HALTED;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        // A redirect lands even on a halting or halted context.
        if (redir_hit && (redir_ctx == CTXW'(i))) begin
          pc[i] <= target;
        end else if (halt_hit && (halt_ctx == CTXW'(i))) begin
          pc[i] <= pc[i];
        end else if (fetch_valid && (sel == CTXW'(i))) begin
          pc[i] <= pc[i] + 32'd4;
        end else begin
          pc[i] <= pc[i];
        end

        if (halt_hit && (halt_ctx == CTXW'(i))) begin
          state[i] <= CTX_HALTED;
        end else if (start[i]) begin
          state[i] <= CTX_RUN;
        end else begin
          state[i] <= state[i];
        end
      end

      if (fetch_valid) begin
        rr_ptr <= (sel == CTXW'(NCTX - 1)) ? '0 : (sel + CTXW'(1));
      end else begin
        rr_ptr <= rr_ptr;
      end
    end
  end

endmodule

// File: tb/tb_pc_mt_unit.sv
// Scoreboard bench for pc_mt_unit with two contexts and round-robin select.
module tb_pc_mt_unit;
  import pc_mt_unit_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        pcEN;
  logic        redir_valid;
  logic [0:0]  redir_ctx;
  logic [31:0] redir_pc;
  logic [1:0]  pc_src;
  logic        branchmux;
  logic [31:0] imm16;
  logic [25:0] imm26;
  logic [31:0] regval;
  logic        halt_req;
  logic [0:0]  halt_ctx;
  logic [1:0]  start;
  logic [31:0] imemaddr;
  logic [0:0]  fetch_ctx;
  logic        fetch_valid;
  logic [1:0]  halted;
  logic        all_halted;

  int          n_cmp;
  int          n_err;
  logic        mon_en;
  logic [32:0] exp_q [$];

  pc_mt_unit dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .pcEN        (pcEN),
    .redir_valid (redir_valid),
    .redir_ctx   (redir_ctx),
    .redir_pc    (redir_pc),
    .pc_src      (pc_src),
    .branchmux   (branchmux),
    .imm16       (imm16),
    .imm26       (imm26),
    .regval      (regval),
    .halt_req    (halt_req),
    .halt_ctx    (halt_ctx),
    .start       (start),
    .imemaddr    (imemaddr),
    .fetch_ctx   (fetch_ctx),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .all_halted  (all_halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic ctx, input logic [31:0] addr);
    exp_q.push_back({ctx, addr});
  endtask

  // Advance one cycle; one-cycle request pulses are dropped after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
    redir_valid = 1'b0;
    halt_req    = 1'b0;
    start       = 2'b00;
  endtask

  task automatic redir(input logic c, input logic [1:0] src, input logic [31:0] rpc,
                       input logic bm, input logic [31:0] i16, input logic [25:0] i26,
                       input logic [31:0] rv);
    redir_valid = 1'b1;
    redir_ctx   = c;
    pc_src      = src;
    redir_pc    = rpc;
    branchmux   = bm;
    imm16       = i16;
    imm26       = i26;
    regval      = rv;
  endtask

  task automatic halt(input logic c);
    halt_req = 1'b1;
    halt_ctx = c;
  endtask

  // Compare every valid fetch against the oldest expected fetch.
  always @(negedge CLK) begin
    if (mon_en && fetch_valid) begin
      if (exp_q.size() == 0) begin
        check_val("fetch_unexpected", 64'({fetch_ctx, imemaddr}), 64'h1_FFFF_FFFF_FFFF);
      end else begin
        check_val("fetch", 64'({fetch_ctx, imemaddr}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; mon_en = 1'b0;
    nRST = 1'b0; pcEN = 1'b1;
    redir_valid = 1'b0; redir_ctx = 1'b0; redir_pc = 32'h0; pc_src = PC_SEQ;
    branchmux = 1'b0; imm16 = 32'h0; imm26 = 26'h0; regval = 32'h0;
    halt_req = 1'b0; halt_ctx = 1'b0; start = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1; mon_en = 1'b1;

    // c0..c2: only ctx0 runs after reset
    push_fetch(1'b0, 32'h0);
    #2;
    check_val("rst_halted", 64'(halted), 64'h2);
    check_val("rst_all_halted", 64'(all_halted), 64'h0);
    check_val("rst_valid", 64'(fetch_valid), 64'h1);
    check_val("rst_addr", 64'(imemaddr), 64'h0);
    check_val("rst_ctx", 64'(fetch_ctx), 64'h0);
    cyc();
    push_fetch(1'b0, 32'h4); cyc();
    push_fetch(1'b0, 32'h8); start = 2'b10; cyc();
    // c3..c6: both run; rr pointer already points at ctx1
    push_fetch(1'b1, 32'h200);
    #2; check_val("start_halted", 64'(halted), 64'h0);
    cyc();
    push_fetch(1'b0, 32'hC);   cyc();
    push_fetch(1'b1, 32'h204); cyc();
    push_fetch(1'b0, 32'h10);  cyc();
    // c7..c10: branch redirects on ctx0
    push_fetch(1'b1, 32'h208);
    redir(1'b0, PC_BR, 32'h40, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0); cyc();
    push_fetch(1'b0, 32'h3C);  cyc();
    push_fetch(1'b1, 32'h20C);
    redir(1'b0, PC_BR, 32'h40, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0); cyc();
    push_fetch(1'b0, 32'h44);  cyc();
    // c11..c16: jump, jr overriding same-cycle advance, seq redirect ignored
    push_fetch(1'b1, 32'h210);
    redir(1'b0, PC_J, 32'hF000_0010, 1'b0, 32'h0, 26'h100, 32'h0); cyc();
    push_fetch(1'b0, 32'hF000_0400); cyc();
    push_fetch(1'b1, 32'h214);
    redir(1'b1, PC_JR, 32'h0, 1'b0, 32'h0, 26'h0, 32'h1237); cyc();
    push_fetch(1'b0, 32'hF000_0404); cyc();
    push_fetch(1'b1, 32'h1234);
    redir(1'b0, PC_SEQ, 32'h800, 1'b1, 32'h10, 26'h0, 32'h0); cyc();
    push_fetch(1'b0, 32'hF000_0408); cyc();
    // c17..c20: halt ctx1 with same-cycle redirect; halt beats start
    push_fetch(1'b1, 32'h1238);
    halt(1'b1);
    redir(1'b1, PC_JR, 32'h0, 1'b0, 32'h0, 26'h0, 32'h3000); cyc();
    push_fetch(1'b0, 32'hF000_040C);
    #2; check_val("halt1_halted", 64'(halted), 64'h2);
    cyc();
    push_fetch(1'b0, 32'hF000_0410);
    halt(1'b1); start = 2'b10; cyc();
    push_fetch(1'b0, 32'hF000_0414);
    #2; check_val("halt_wins", 64'(halted), 64'h2);
    halt(1'b0); cyc();
    // c21: nothing runnable
    #2;
    check_val("none_valid", 64'(fetch_valid), 64'h0);
    check_val("none_all_halted", 64'(all_halted), 64'h1);
    check_val("none_addr", 64'(imemaddr), 64'h3000);
    check_val("none_ctx", 64'(fetch_ctx), 64'h1);
    start = 2'b01; cyc();
    // c22: ctx0 restarted but stalled
    pcEN = 1'b0;
    #2;
    check_val("stall_valid", 64'(fetch_valid), 64'h0);
    check_val("stall_addr", 64'(imemaddr), 64'hF000_0414);
    cyc();
    // c23..c25: resume, redirect to top of address space and wrap
    pcEN = 1'b1;
    push_fetch(1'b0, 32'hF000_0414);
    redir(1'b0, PC_JR, 32'h0, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC); cyc();
    push_fetch(1'b0, 32'hFFFF_FFFC); cyc();
    push_fetch(1'b0, 32'h0); cyc();
    // c26: reset with requests pending
    mon_en = 1'b0; nRST = 1'b0;
    halt(1'b0); start = 2'b10;
    redir(1'b0, PC_JR, 32'h0, 1'b0, 32'h0, 26'h0, 32'h5000); cyc();
    // c27..c28: back to reset state
    nRST = 1'b1; mon_en = 1'b1;
    push_fetch(1'b0, 32'h0);
    #2;
    check_val("mid_rst_halted", 64'(halted), 64'h2);
    check_val("mid_rst_all_halted", 64'(all_halted), 64'h0);
    check_val("mid_rst_addr", 64'(imemaddr), 64'h0);
    cyc();
    push_fetch(1'b0, 32'h4); cyc();
    #2;
    check_val("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
